// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// Optional feature macro: SERIAL_SUB_OVF_EN (signed overflow output).
package serial_sub_pkg;

  // Default operand width.
  localparam int SUB_W_DEFAULT = 8;

  // Controller states: waiting for start, shifting bits, result pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);

  // Difference bit and borrow-out; borrow when x < y + bin.
  always_comb begin
    d  = x ^ y ^ bin;
    bo = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin over W cycles, LSB first,
// using one full-subtractor cell and a single borrow flop.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed overflow
// output 'ovf' together with its register and the operand MSB captures.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int W = SUB_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic         ovf,
`endif
  output logic         bout
);

  localparam int CW = $clog2(W);

  sub_state_t    state;
  sub_state_t    state_next;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  res;
  logic          br;
  logic [CW-1:0] cnt;
  logic          bout_q;
  logic          cell_d;
  logic          cell_bo;
  logic          last_bit;

`ifdef SERIAL_SUB_OVF_EN
  logic          a_msb;
  logic          b_msb;
  logic          ovf_q;
`endif

  // The single cell sees the current LSBs of the operand shifters.
  full_subtractor u_cell (
    .x   (a_sh[0]),
    .y   (b_sh[0]),
    .bin (br),
    .d   (cell_d),
    .bo  (cell_bo)
  );

  assign last_bit = (cnt == CW'(W - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start is only honoured in IDLE, no queueing.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load operands on accepted start, shift one bit per RUN edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      bout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            br   <= bin;
            cnt  <= '0;
          end
        end
        RUN: begin
          res  <= {cell_d, res[W-1:1]};
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= cell_bo;
          cnt  <= cnt + 1'b1;
          if (last_bit) begin
            bout_q <= cell_bo;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Signed overflow: operand signs differ and result sign differs from a.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        a_msb <= a[W-1];
        b_msb <= b[W-1];
      end
      if (state == RUN && last_bit) begin
        ovf_q <= (a_msb ^ b_msb) & (a_msb ^ cell_d);
      end
    end
  end

  assign ovf = ovf_q;
`endif

  // Outputs come straight from flops or decoded state only.
  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign diff = res;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (W=8): vector table,
// hand-written corner sequences and random back-to-back operations,
// all checked through an expected-result queue popped on 'done'.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int   checks;
  int   errors;
  int   txn;
  exp_t sb[$];
  vec_t vecs[8];

  serial_subtractor #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
`ifdef SERIAL_SUB_OVF_EN
    .ovf   (ovf),
`endif
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: {bout,diff} is a - b - bin taken over W+1 bits.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
    exp_t        e;
    logic [W:0]  r;
    r    = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    e.d  = r[W-1:0];
    e.bo = r[W];
    e.ov = (ma[W-1] ^ mb[W-1]) & (ma[W-1] ^ r[W-1]);
    return e;
  endfunction

  // Called at a negedge; leaves start high so the next call can chain.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin, input exp_t e);
    int guard;
    a     = ia;
    b     = ib;
    bin   = ibin;
    start = 1'b1;
    sb.push_back(e);
    guard = 0;
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("issue_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic drain();
    int guard;
    start = 1'b0;
    guard = 0;
    while ((sb.size() != 0 || busy) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("drain_timeout", 32'd1, 32'd0);
  endtask

  // Monitor: pop and compare one expected result per done pulse.
  initial begin : monitor
    exp_t e;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        check("done_single_cycle", {31'd0, prev_done}, 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          txn++;
          $display("txn %0d diff=%02h bout=%0b (expect %02h %0b)", txn, diff, bout, e.d, e.bo);
          check("diff", {24'd0, diff}, {24'd0, e.d});
          check("bout", {31'd0, bout}, {31'd0, e.bo});
`ifdef SERIAL_SUB_OVF_EN
          check("ovf", {31'd0, ovf}, {31'd0, e.ov});
`endif
        end
      end
      prev_done = done;
    end
  end

  initial begin : main
    exp_t e;
    int   n;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rbin;

    checks = 0;
    errors = 0;
    txn    = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    bin    = 1'b0;

    vecs[0] = '{a: 8'h5A, b: 8'h3C, bin: 1'b0, d: 8'h1E, bo: 1'b0, ov: 1'b0};
    vecs[1] = '{a: 8'h00, b: 8'h01, bin: 1'b0, d: 8'hFF, bo: 1'b1, ov: 1'b0};
    vecs[2] = '{a: 8'h10, b: 8'h0F, bin: 1'b1, d: 8'h00, bo: 1'b0, ov: 1'b0};
    vecs[3] = '{a: 8'h80, b: 8'h01, bin: 1'b0, d: 8'h7F, bo: 1'b0, ov: 1'b1};
    vecs[4] = '{a: 8'h00, b: 8'hFF, bin: 1'b1, d: 8'h00, bo: 1'b1, ov: 1'b0};
    vecs[5] = '{a: 8'hFF, b: 8'hFF, bin: 1'b1, d: 8'hFF, bo: 1'b1, ov: 1'b0};
    vecs[6] = '{a: 8'h7F, b: 8'hFF, bin: 1'b0, d: 8'h80, bo: 1'b1, ov: 1'b1};
    vecs[7] = '{a: 8'hFF, b: 8'h00, bin: 1'b0, d: 8'hFF, bo: 1'b0, ov: 1'b0};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_bout", {31'd0, bout}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Latency and busy window for a single operation.
    a     = 8'h5A;
    b     = 8'h3C;
    bin   = 1'b0;
    start = 1'b1;
    sb.push_back(exp_t'{d: 8'h1E, bo: 1'b0, ov: 1'b0});
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    n = 1;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("done_latency", n, W + 1);
    check("busy_in_done", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("busy_after_done", {31'd0, busy}, 32'd0);
    check("done_cleared", {31'd0, done}, 32'd0);
    check("diff_held", {24'd0, diff}, 32'h1E);

    // Vector table, chained back-to-back.
    for (int i = 0; i < 8; i++) begin
      e.d  = vecs[i].d;
      e.bo = vecs[i].bo;
      e.ov = vecs[i].ov;
      issue(vecs[i].a, vecs[i].b, vecs[i].bin, e);
    end
    drain();

    // Start during RUN is ignored.
    issue(8'h20, 8'h01, 1'b0, exp_t'{d: 8'h1F, bo: 1'b0, ov: 1'b0});
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a     = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (W + 4) @(negedge clk);
    check("no_extra_op", sb.size(), 0);

    // Asynchronous reset mid-RUN clears everything at once.
    issue(8'h33, 8'h11, 1'b0, exp_t'{d: 8'h22, bo: 1'b0, ov: 1'b0});
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_diff", {24'd0, diff}, 32'd0);
    check("midrst_bout", {31'd0, bout}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("midrst_ovf", {31'd0, ovf}, 32'd0);
`endif
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(8'h09, 8'h04, 1'b0, exp_t'{d: 8'h05, bo: 1'b0, ov: 1'b0});
    drain();

    // Random back-to-back operations against the W+1-bit model.
    for (int i = 0; i < 1000; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom_range(0, 1));
      issue(ra, rb, rbin, model(ra, rb, rbin));
    end
    drain();

    check("ops_completed", txn, 1000 + 8 + 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
